// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: holds one decoded instruction pair (A older, B younger)
// and issues it in order to the even/odd pipes, gated by a per-register
// latency scoreboard (RAW/WAW) and the pipe-pairing rules.
module dual_issue_scheduler #(
    parameter int          NREG   = 128,
    parameter int          ADDR_W = 7,
    parameter int          LAT_W  = 3,
    parameter logic [31:0] NOP_E  = 32'h40200000,
    parameter logic [31:0] NOP_O  = 32'h00200000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in0_inst,
    input  logic              in0_pipe,
    input  logic [ADDR_W-1:0] in0_rt,
    input  logic [ADDR_W-1:0] in0_ra,
    input  logic [ADDR_W-1:0] in0_rb,
    input  logic [ADDR_W-1:0] in0_rc,
    input  logic [2:0]        in0_rmask,
    input  logic              in0_wr,
    input  logic [LAT_W-1:0]  in0_lat,
    input  logic [31:0]       in1_inst,
    input  logic              in1_pipe,
    input  logic [ADDR_W-1:0] in1_rt,
    input  logic [ADDR_W-1:0] in1_ra,
    input  logic [ADDR_W-1:0] in1_rb,
    input  logic [ADDR_W-1:0] in1_rc,
    input  logic [2:0]        in1_rmask,
    input  logic              in1_wr,
    input  logic [LAT_W-1:0]  in1_lat,
    input  logic              flush,
    output logic [31:0]       instructionEven,
    output logic [31:0]       instructionOdd,
    output logic              validEven,
    output logic              validOdd,
    output logic [31:0]       stall_cnt
);

    typedef struct packed {
        logic              v;
        logic [31:0]       inst;
        logic              pipe;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] ra;
        logic [ADDR_W-1:0] rb;
        logic [ADDR_W-1:0] rc;
        logic [2:0]        rmask;
        logic              wr;
        logic [LAT_W-1:0]  lat;
    } slot_t;

    slot_t             r_a;
    slot_t             r_b;
    logic [LAT_W-1:0]  r_cnt [NREG];
    logic [31:0]       r_even;
    logic [31:0]       r_odd;
    logic              r_ve;
    logic              r_vo;
    logic [31:0]       r_stall;

    slot_t             w_in0;
    slot_t             w_in1;
    logic              w_a_ok;
    logic              w_b_ok;
    logic              w_b_dep;
    logic              w_iss_a;
    logic              w_iss_b;
    logic              w_xfer;
    logic [31:0]       w_even_nxt;
    logic [31:0]       w_odd_nxt;
    logic              w_ve_nxt;
    logic              w_vo_nxt;

    // Scoreboard load value: a result with latency L becomes forwardable after L cycles.
    function automatic logic [LAT_W-1:0] lat_load(input logic [LAT_W-1:0] lat);
        return (lat == '0) ? '0 : lat - 1'b1;
    endfunction

    // Pack the incoming pair into slot records.
    always_comb begin
        w_in0 = '{v: 1'b1, inst: in0_inst, pipe: in0_pipe, rt: in0_rt, ra: in0_ra,
                  rb: in0_rb, rc: in0_rc, rmask: in0_rmask, wr: in0_wr, lat: in0_lat};
        w_in1 = '{v: 1'b1, inst: in1_inst, pipe: in1_pipe, rt: in1_rt, ra: in1_ra,
                  rb: in1_rb, rc: in1_rc, rmask: in1_rmask, wr: in1_wr, lat: in1_lat};
    end

    // Per-slot readiness (sources and WAW) and the pair issue decision.
    always_comb begin
        w_a_ok  = r_a.v
                  && (!r_a.rmask[2] || r_cnt[r_a.ra] == '0)
                  && (!r_a.rmask[1] || r_cnt[r_a.rb] == '0)
                  && (!r_a.rmask[0] || r_cnt[r_a.rc] == '0)
                  && (!r_a.wr       || r_cnt[r_a.rt] == '0);
        w_b_ok  = r_b.v
                  && (!r_b.rmask[2] || r_cnt[r_b.ra] == '0)
                  && (!r_b.rmask[1] || r_cnt[r_b.rb] == '0)
                  && (!r_b.rmask[0] || r_cnt[r_b.rc] == '0)
                  && (!r_b.wr       || r_cnt[r_b.rt] == '0);
        w_b_dep = r_a.wr && ((r_b.rmask[2] && r_b.ra == r_a.rt)
                          || (r_b.rmask[1] && r_b.rb == r_a.rt)
                          || (r_b.rmask[0] && r_b.rc == r_a.rt));
        w_iss_a = w_a_ok && !flush;
        w_iss_b = w_iss_a && w_b_ok && (r_b.pipe != r_a.pipe) && !w_b_dep;
        in_ready = !r_a.v && !r_b.v;
        w_xfer   = in_valid && in_ready && !flush;
    end

    // Route issued words to their pipe ports; idle ports carry the filler.
    always_comb begin
        w_even_nxt = NOP_E;
        w_odd_nxt  = NOP_O;
        w_ve_nxt   = 1'b0;
        w_vo_nxt   = 1'b0;
        if (w_iss_a) begin
            if (r_a.pipe) begin
                w_odd_nxt = r_a.inst;
                w_vo_nxt  = 1'b1;
            end else begin
                w_even_nxt = r_a.inst;
                w_ve_nxt   = 1'b1;
            end
        end
        if (w_iss_b) begin
            if (r_b.pipe) begin
                w_odd_nxt = r_b.inst;
                w_vo_nxt  = 1'b1;
            end else begin
                w_even_nxt = r_b.inst;
                w_ve_nxt   = 1'b1;
            end
        end
    end

    // Scoreboard: issuing writers load their latency, others count down to zero.
    // B wins a same-register load because it is the younger writer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_iss_b && r_b.wr && r_b.rt == ADDR_W'(i))
                    r_cnt[i] <= lat_load(r_b.lat);
                else if (w_iss_a && r_a.wr && r_a.rt == ADDR_W'(i))
                    r_cnt[i] <= lat_load(r_a.lat);
                else if (r_cnt[i] != '0)
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    // Slot holding: accept into empty slots, retire issued slots, shift B into A.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (flush) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_xfer) begin
            r_a <= w_in0;
            r_b <= w_in1;
        end else if (w_iss_a) begin
            r_a <= w_iss_b ? '0 : r_b;
            r_b <= '0;
        end
    end

    // Registered issue ports and the stall counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_even  <= NOP_E;
            r_odd   <= NOP_O;
            r_ve    <= 1'b0;
            r_vo    <= 1'b0;
            r_stall <= '0;
        end else begin
            r_even <= w_even_nxt;
            r_odd  <= w_odd_nxt;
            r_ve   <= w_ve_nxt;
            r_vo   <= w_vo_nxt;
            if (r_a.v && !w_a_ok && !flush)
                r_stall <= r_stall + 32'd1;
        end
    end

    assign instructionEven = r_even;
    assign instructionOdd  = r_odd;
    assign validEven       = r_ve;
    assign validOdd        = r_vo;
    assign stall_cnt       = r_stall;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Directed, table-driven bench for dual_issue_scheduler.
module tb_dual_issue_scheduler;

    localparam logic [31:0] NE = 32'h40200000;
    localparam logic [31:0] NO = 32'h00200000;

    typedef struct packed {
        logic [31:0] inst;
        logic        pipe;
        logic [6:0]  rt;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic [2:0]  rmask;
        logic        wr;
        logic [2:0]  lat;
    } ins_t;

    typedef struct packed {
        logic        vld;
        logic        fl;
        ins_t        i0;
        ins_t        i1;
        logic [31:0] e_even;
        logic [31:0] e_odd;
        logic        e_ve;
        logic        e_vo;
        logic        e_rdy;
        logic [31:0] e_stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    ins_t        d0 = '0;
    ins_t        d1 = '0;
    logic        in_ready;
    logic [31:0] instructionEven, instructionOdd, stall_cnt;
    logic        validEven, validOdd;

    int n_chk  = 0;
    int n_pass = 0;

    vec_t tbl [25];

    always #5 clk = ~clk;

    dual_issue_scheduler dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in0_inst(d0.inst), .in0_pipe(d0.pipe), .in0_rt(d0.rt), .in0_ra(d0.ra),
        .in0_rb(d0.rb), .in0_rc(d0.rc), .in0_rmask(d0.rmask), .in0_wr(d0.wr), .in0_lat(d0.lat),
        .in1_inst(d1.inst), .in1_pipe(d1.pipe), .in1_rt(d1.rt), .in1_ra(d1.ra),
        .in1_rb(d1.rb), .in1_rc(d1.rc), .in1_rmask(d1.rmask), .in1_wr(d1.wr), .in1_lat(d1.lat),
        .flush(flush),
        .instructionEven(instructionEven), .instructionOdd(instructionOdd),
        .validEven(validEven), .validOdd(validOdd), .stall_cnt(stall_cnt)
    );

    function automatic ins_t mk(input logic [31:0] inst, input logic pipe,
                                input logic [6:0] rt, input logic [6:0] ra,
                                input logic [6:0] rb, input logic [6:0] rc,
                                input logic [2:0] rmask, input logic wr,
                                input logic [2:0] lat);
        ins_t r;
        r.inst = inst; r.pipe = pipe; r.rt = rt; r.ra = ra; r.rb = rb; r.rc = rc;
        r.rmask = rmask; r.wr = wr; r.lat = lat;
        return r;
    endfunction

    function automatic vec_t mkv(input logic vld, input logic fl, input ins_t i0, input ins_t i1,
                                 input logic [31:0] ee, input logic [31:0] eo,
                                 input logic eve, input logic evo, input logic erdy,
                                 input logic [31:0] est);
        vec_t v;
        v.vld = vld; v.fl = fl; v.i0 = i0; v.i1 = i1;
        v.e_even = ee; v.e_odd = eo; v.e_ve = eve; v.e_vo = evo; v.e_rdy = erdy; v.e_stall = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic check_outs(input string tag, input vec_t v);
        chk({tag, ".even"},  instructionEven, v.e_even);
        chk({tag, ".odd"},   instructionOdd,  v.e_odd);
        chk({tag, ".vEven"}, {31'd0, validEven}, {31'd0, v.e_ve});
        chk({tag, ".vOdd"},  {31'd0, validOdd},  {31'd0, v.e_vo});
        chk({tag, ".ready"}, {31'd0, in_ready},  {31'd0, v.e_rdy});
        chk({tag, ".stall"}, stall_cnt, v.e_stall);
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        in_valid = v.vld;
        flush    = v.fl;
        d0       = v.i0;
        d1       = v.i1;
        @(posedge clk);
        #1;
        check_outs(tag, v);
    endtask

    ins_t z;
    ins_t ob;

    initial begin
        z  = mk(32'h0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, 3'd1);
        ob = mk(32'h21000000, 1'b1, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 1'b0, 3'd1);

        // Independent pair (A odd shlqby rt8, B even add rt4), then RAW lat 3 and lat 7.
        tbl[0]  = mkv(1, 0, mk(32'h3BF00408, 1, 8, 3, 5, 0, 3'b110, 1, 4),
                            mk(32'h18010204, 0, 4, 1, 2, 0, 3'b110, 1, 2),
                      NE, NO, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, z, z, 32'h18010204, 32'h3BF00408, 1, 1, 1, 0);
        tbl[2]  = mkv(0, 0, z, z, NE, NO, 0, 0, 1, 0);
        tbl[3]  = mkv(1, 0, mk(32'h11000001, 0, 10, 0, 0, 0, 3'b000, 1, 3),
                            mk(32'h21000001, 1, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 0, 0);
        tbl[4]  = mkv(0, 0, z, z, 32'h11000001, 32'h21000001, 1, 1, 1, 0);
        tbl[5]  = mkv(1, 0, mk(32'h11000002, 0, 0, 10, 0, 0, 3'b100, 0, 1),
                            mk(32'h21000002, 1, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 0, 0);
        tbl[6]  = mkv(1, 0, mk(32'h1100FFFF, 0, 0, 0, 0, 0, 3'b000, 0, 1), ob,
                      NE, NO, 0, 0, 0, 1);
        tbl[7]  = mkv(0, 0, z, z, 32'h11000002, 32'h21000002, 1, 1, 1, 1);
        tbl[8]  = mkv(1, 0, mk(32'h11000003, 0, 11, 0, 0, 0, 3'b000, 1, 7),
                            mk(32'h21000003, 1, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 0, 1);
        tbl[9]  = mkv(0, 0, z, z, 32'h11000003, 32'h21000003, 1, 1, 1, 1);
        tbl[10] = mkv(1, 0, mk(32'h11000004, 0, 0, 0, 11, 0, 3'b010, 0, 1),
                            mk(32'h21000004, 1, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++)
            tbl[11 + k] = mkv(0, 0, z, z, NE, NO, 0, 0, 0, 32'(2 + k));
        tbl[16] = mkv(0, 0, z, z, 32'h11000004, 32'h21000004, 1, 1, 1, 6);
        // Intra-pair dependency on r12.
        tbl[17] = mkv(1, 0, mk(32'h11000005, 0, 12, 0, 0, 0, 3'b000, 1, 2),
                            mk(32'h21000005, 1, 0, 0, 0, 12, 3'b001, 0, 1), NE, NO, 0, 0, 0, 6);
        tbl[18] = mkv(0, 0, z, z, 32'h11000005, NO, 1, 0, 0, 6);
        tbl[19] = mkv(0, 0, z, z, NE, NO, 0, 0, 0, 7);
        tbl[20] = mkv(0, 0, z, z, NE, 32'h21000005, 0, 1, 1, 7);
        // Both slots in the even pipe.
        tbl[21] = mkv(1, 0, mk(32'h11000006, 0, 0, 0, 0, 0, 3'b000, 0, 1),
                            mk(32'h11000007, 0, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 0, 7);
        tbl[22] = mkv(0, 0, z, z, 32'h11000006, NO, 1, 0, 0, 7);
        tbl[23] = mkv(0, 0, z, z, 32'h11000007, NO, 1, 0, 1, 7);
        tbl[24] = mkv(0, 0, z, z, NE, NO, 0, 0, 1, 7);

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check_outs("por", mkv(0, 0, z, z, NE, NO, 0, 0, 1, 0));
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 25; k++)
            step($sformatf("v%0d", k), tbl[k]);

        // Flush while B waits on r20; r20 keeps counting through the flush.
        step("f0", mkv(1, 0, mk(32'h11000008, 0, 20, 0, 0, 0, 3'b000, 1, 5),
                             mk(32'h21000008, 1, 0, 20, 0, 0, 3'b100, 0, 1), NE, NO, 0, 0, 0, 7));
        step("f1", mkv(0, 0, z, z, 32'h11000008, NO, 1, 0, 0, 7));
        step("f2", mkv(0, 0, z, z, NE, NO, 0, 0, 0, 8));
        step("f3", mkv(1, 1, mk(32'h1100DEAD, 0, 0, 0, 0, 0, 3'b000, 0, 1),
                             mk(32'h2100DEAD, 1, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 1, 8));
        step("f4", mkv(1, 0, mk(32'h21000009, 1, 0, 0, 20, 0, 3'b010, 0, 1),
                             mk(32'h11000009, 0, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 0, 8));
        step("f5", mkv(0, 0, z, z, NE, NO, 0, 0, 0, 9));
        step("f6", mkv(0, 0, z, z, 32'h11000009, 32'h21000009, 1, 1, 1, 9));

        // Asynchronous reset mid-run with B held waiting on r4 (cnt[4]=5).
        step("r0", mkv(1, 0, mk(32'h1100000A, 0, 4, 0, 0, 0, 3'b000, 1, 6),
                             mk(32'h2100000A, 1, 0, 0, 0, 4, 3'b001, 0, 1), NE, NO, 0, 0, 0, 9));
        step("r1", mkv(0, 0, z, z, 32'h1100000A, NO, 1, 0, 0, 9));
        #2;
        reset = 1'b0;
        #1;
        check_outs("rst", mkv(0, 0, z, z, NE, NO, 0, 0, 1, 0));
        @(negedge clk);
        reset = 1'b1;
        step("r3", mkv(1, 0, mk(32'h1100000B, 0, 0, 4, 0, 0, 3'b100, 0, 1),
                             mk(32'h2100000B, 1, 0, 0, 0, 0, 3'b000, 0, 1), NE, NO, 0, 0, 0, 0));
        step("r4", mkv(0, 0, z, z, 32'h1100000B, 32'h2100000B, 1, 1, 1, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
